// File: rtl/reg_file_pkg.sv
// Shared definitions for the reg_file register bank: write-op encoding and default geometry.
package reg_file_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_SHL  = 2'd3
  } wop_e;
endpackage

// File: rtl/reg_file_if.sv
// Write port plus two read ports of the register bank; master drives, slave is the bank.
interface reg_file_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [1:0]       wop;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [WIDTH-1:0] rdata_a_n;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic [WIDTH-1:0] rdata_b_n;
  logic             carry;

  modport master (
    output we, wop, waddr, wdata, raddr_a, raddr_b,
    input  rdata_a, rdata_a_n, rdata_b, rdata_b_n, carry
  );

  modport slave (
    input  we, wop, waddr, wdata, raddr_a, raddr_b,
    output rdata_a, rdata_a_n, rdata_b, rdata_b_n, carry
  );
endinterface

// File: rtl/reg_file_next.sv
// Combinational update of one register for LOAD/INC/DEC/SHL, shared by the write and bypass paths.
module reg_file_next
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] cur,
  input  wop_e             wop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] nxt,
  output logic             nxt_carry,
  output logic             carry_upd
);
  always_comb begin
    nxt       = cur;
    nxt_carry = 1'b0;
    carry_upd = 1'b0;
    case (wop)
      OP_LOAD: nxt = wdata;
      OP_INC: begin
        {nxt_carry, nxt} = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
        carry_upd        = 1'b1;
      end
      OP_DEC: begin
        nxt       = cur - {{(WIDTH-1){1'b0}}, 1'b1};
        nxt_carry = (cur == '0);
        carry_upd = 1'b1;
      end
      OP_SHL: begin
        nxt       = {cur[WIDTH-2:0], wdata[0]};
        nxt_carry = cur[WIDTH-1];
        carry_upd = 1'b1;
      end
      default: nxt = cur;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// DEPTH x WIDTH register bank, one modifying write port, two combinational true/complement read ports.
// Optional write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input logic      clk,
  input logic      rst_n,
  reg_file_if.slave bus
);
  logic [DEPTH-1:0][WIDTH-1:0] regs_q, regs_d;
  logic                        carry_q, carry_d;
  logic [WIDTH-1:0]            wcur, wnxt;
  logic                        wnxt_c, wc_upd, whit, wr_en;
  logic [WIDTH-1:0]            rd_a, rd_b;

  // Address decode by loop: an address with no matching register (>= DEPTH) simply never hits.
  function automatic logic [WIDTH-1:0] rd_sel(input logic [AW-1:0] a,
                                              input logic [DEPTH-1:0][WIDTH-1:0] r);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++)
      if (a == AW'(i)) v = r[i];
    return v;
  endfunction

  always_comb begin
    wcur = '0;
    whit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.waddr == AW'(i)) begin
        wcur = regs_q[i];
        whit = 1'b1;
      end
    end
  end

  assign wr_en = bus.we & whit;

  reg_file_next #(.WIDTH(WIDTH)) u_next (
    .cur       (wcur),
    .wop       (wop_e'(bus.wop)),
    .wdata     (bus.wdata),
    .nxt       (wnxt),
    .nxt_carry (wnxt_c),
    .carry_upd (wc_upd)
  );

  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++)
        if (bus.waddr == AW'(i)) regs_d[i] = wnxt;
      if (wc_upd) carry_d = wnxt_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forward the in-flight write result; carry stays registered-only.
  assign rd_a = (wr_en && bus.raddr_a == bus.waddr) ? wnxt : rd_sel(bus.raddr_a, regs_q);
  assign rd_b = (wr_en && bus.raddr_b == bus.waddr) ? wnxt : rd_sel(bus.raddr_b, regs_q);
`else
  assign rd_a = rd_sel(bus.raddr_a, regs_q);
  assign rd_b = rd_sel(bus.raddr_b, regs_q);
`endif

  assign bus.rdata_a   = rd_a;
  assign bus.rdata_a_n = ~rd_a;
  assign bus.rdata_b   = rd_b;
  assign bus.rdata_b_n = ~rd_b;
  assign bus.carry     = carry_q;
endmodule
